// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative RV32M multiply/divide sequencer.
// One request is accepted over a valid/ready handshake. A 32-step shift-add
// multiply or restoring divide then runs on operand magnitudes, the sign is
// corrected on the way into DONE, and the result is held until the consumer
// takes it.
// Build option: define MDU_DIV_EN to include the divider. Without it, divide
// opcodes are accepted and answered one cycle later with err_o=1 and result 0.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_fun_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            err_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef MDU_DIV_EN
        S_DIV,
`endif
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;    // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   r_opb;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [1:0]        r_fun;    // low funct3 bits select low/high half or quotient/remainder
    logic              r_neg;    // negate product or quotient at the end
    logic [XLEN-1:0]   r_result;

    // ---------------- operand decode at accept ----------------
    logic            w_last;
    logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;

    assign w_last  = (r_cnt == CW'(XLEN - 1));
    // Divides are signed when funct3[0]==0; for multiplies only MULHU has an
    // unsigned a, and MULHSU/MULHU have an unsigned b.
    assign w_a_sgn = req_fun_i[2] ? ~req_fun_i[0] : (req_fun_i[1:0] != 2'd3);
    assign w_b_sgn = req_fun_i[2] ? ~req_fun_i[0] : ~req_fun_i[1];
    assign w_a_neg = w_a_sgn & rs1_i[XLEN-1];
    assign w_b_neg = w_b_sgn & rs2_i[XLEN-1];
    assign w_a_mag = w_a_neg ? -rs1_i : rs1_i;
    assign w_b_mag = w_b_neg ? -rs2_i : rs2_i;

    // ---------------- multiply step ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt, w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg ? -w_mul_nxt : w_mul_nxt;
    assign w_mul_res = (r_fun == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    // ---------------- divide step and special cases ----------------
    logic              r_neg_a;  // remainder takes the sign of the dividend
    logic [XLEN:0]     w_div_shift, w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [XLEN-1:0]   w_quo, w_rem, w_div_res;
    logic              w_div_zero, w_div_ovf, w_div_special;
    logic [XLEN-1:0]   w_special_res;

    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = ~w_div_diff[XLEN];
    assign w_div_nxt   = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                          r_acc[XLEN-2:0], w_div_ge};
    assign w_quo       = w_div_nxt[XLEN-1:0];
    assign w_rem       = w_div_nxt[2*XLEN-1:XLEN];
    assign w_div_res   = r_fun[1] ? (r_neg_a ? -w_rem : w_rem) : (r_neg ? -w_quo : w_quo);

    assign w_div_zero    = (rs2_i == '0);
    assign w_div_ovf     = ~req_fun_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    assign w_div_special = w_div_zero | w_div_ovf;
    // Zero divisor: quotient all ones, remainder a. Overflow: quotient a (MIN), remainder 0.
    assign w_special_res = w_div_zero ? (req_fun_i[1] ? rs1_i : '1)
                                      : (req_fun_i[1] ? '0 : rs1_i);
    assign err_o = 1'b0;
`else
    logic r_err;
    assign err_o = r_err;
`endif

    assign result_o = r_result;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake decodes; outputs depend on the state register only.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    if (!req_fun_i[2])      w_state_nxt = S_MUL;
`ifdef MDU_DIV_EN
                    else if (w_div_special) w_state_nxt = S_DONE;
                    else                    w_state_nxt = S_DIV;
`else
                    else                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_MUL: if (w_last) w_state_nxt = S_DONE;
`ifdef MDU_DIV_EN
            S_DIV: if (w_last) w_state_nxt = S_DONE;
`endif
            S_DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration and sign-corrected result register.
    always_ff @(posedge clk) begin
        // NOTE: only control-visible registers are reset; r_acc/r_opb/r_fun/r_neg are always loaded at accept before use.
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
`ifndef MDU_DIV_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_fun <= req_fun_i[1:0];
                    r_cnt <= '0;
                    if (!req_fun_i[2]) begin
                        r_acc <= {{XLEN{1'b0}}, w_b_mag};
                        r_opb <= w_a_mag;
                        r_neg <= w_a_neg ^ w_b_neg;
`ifndef MDU_DIV_EN
                        r_err <= 1'b0;
`endif
                    end else begin
`ifdef MDU_DIV_EN
                        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                        r_opb   <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_neg_a <= w_a_neg;
                        if (w_div_special) r_result <= w_special_res;
`else
                        r_result <= '0;
                        r_err    <= 1'b1;
`endif
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_result <= w_mul_res;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_result <= w_div_res;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl (XLEN=32).
// Directed table plus randomized operations compared against a plain
// arithmetic model; expectations follow the MDU_DIV_EN build setting.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_fun_i = 3'd0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        err_o;
    logic        busy_o;

    int n_checks = 0;
    int n_err    = 0;

    mdu_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_fun_i    (req_fun_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic err, input int lat);
        vec_t v;
        v.fun = fun; v.a = a; v.b = b; v.res = res; v.err = err; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference: 64-bit arithmetic on sign/zero-extended operands, SV division for the divide.
    function automatic void model(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic err, output int lat);
        logic signed [63:0] ea, eb, p;
        lat = 33;
        err = 1'b0;
        res = '0;
        if (!fun[2]) begin
            ea  = (fun != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
            eb  = (fun <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
            p   = ea * eb;
            res = (fun == 3'd0) ? p[31:0] : p[63:32];
        end else begin
`ifdef MDU_DIV_EN
            logic [31:0] q, r;
            int sa, sb;
            sa = a;
            sb = b;
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF; r = a; lat = 1;
            end else if (!fun[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0; lat = 1;
            end else if (!fun[0]) begin
                q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
            res = fun[1] ? r : q;
`else
            res = '0; err = 1'b1; lat = 1;
`endif
        end
    endfunction

    // Issue one operation from IDLE, track latency/busy, optionally stall the response.
    task automatic run_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_lat,
                          input int hold, input bit noisy, input string tag);
        int lat;
        bit got, busy_ok, stable_ok;
        check({tag, " req_ready idle"}, req_ready_o, 1);
        req_valid_i = 1'b1; req_fun_i = fun; rs1_i = a; rs2_i = b;
        lat = 0; got = 0; busy_ok = 1;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (noisy) begin
                rs1_i = $urandom; rs2_i = $urandom; req_fun_i = 3'($urandom_range(0, 7));
            end else begin
                req_valid_i = 1'b0;
            end
            if (busy_o !== 1'b1 || req_ready_o !== 1'b0) busy_ok = 0;
            if (resp_valid_o === 1'b1) got = 1;
        end
        check({tag, " response seen"}, got, 1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy/ready during op"}, busy_ok, 1);
        if (got) begin
            check({tag, " result"}, result_o, exp_res);
            check({tag, " err"}, err_o, exp_err);
            if (hold > 0) begin
                stable_ok = 1;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    rs1_i = $urandom;
                    if (result_o !== exp_res || err_o !== exp_err || resp_valid_o !== 1'b1 ||
                        req_ready_o !== 1'b0 || busy_o !== 1'b1) stable_ok = 0;
                end
                check({tag, " held under backpressure"}, stable_ok, 1);
            end
            resp_ready_i = 1'b1;
            req_valid_i  = 1'b0;
            @(negedge clk);
            resp_ready_i = 1'b0;
            check({tag, " resp_valid after handshake"}, resp_valid_o, 0);
            check({tag, " back to idle"}, req_ready_o, 1);
        end else begin
            req_valid_i = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic [2:0]  rf;
        logic        ee;
        int          el;
        bit          spurious;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready_o, 1);
        check("reset busy", busy_o, 0);
        check("reset resp_valid", resp_valid_o, 0);
        check("reset result", result_o, 0);
        check("reset err", err_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- directed table ----------------
        add(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        add(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        add(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        add(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        add(3'd0, 32'd0,          32'd5,         32'd0,         1'b0, 33);
        add(3'd3, 32'h8000_0000,  32'd2,         32'd1,         1'b0, 33);
        add(3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0, 33);
`ifdef MDU_DIV_EN
        add(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33);
        add(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33);
        add(3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b0, 1);
        add(3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1'b0, 1);
        add(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        add(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1);
        add(3'd5, 32'd100,        32'd7,         32'd14,        1'b0, 33);
        add(3'd7, 32'd100,        32'd7,         32'd2,         1'b0, 33);
        add(3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
`else
        add(3'd4, 32'd10,         32'd2,         32'd0,         1'b1, 1);
        add(3'd7, 32'h0000_1234,  32'd0,         32'd0,         1'b1, 1);
`endif
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].lat,
                   0, 1'b0, $sformatf("vec%0d", i));

        // ---------------- backpressure with noisy inputs ----------------
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 5, 1'b1, "bp_mul");
`ifdef MDU_DIV_EN
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 5, 1'b1, "bp_div");
`else
        run_op(3'd4, 32'd10, 32'd2, 32'd0, 1'b1, 1, 5, 1'b1, "bp_div");
`endif

        // ---------------- reset in the middle of a multiply ----------------
        req_valid_i = 1'b1; req_fun_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'd9;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset resp_valid", resp_valid_o, 0);
        check("midreset req_ready", req_ready_o, 1);
        check("midreset busy", busy_o, 0);
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) spurious = 1;
        end
        check("midreset no response", spurious, 0);

        // ---------------- randomized operations ----------------
        for (int n = 0; n < 200; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> (($urandom_range(0, 1)) * 31) : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rf, ra, rb, er, ee, el);
            run_op(rf, ra, rb, er, ee, el, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d f%0d %h %h", n, rf, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
